// File: rtl/design_48_pipe.sv
// Valid/ready ALU pipeline: add/sub/and/xor with carry/borrow/zero flag,
// DEPTH elastic stages that fill under backpressure, and a delivered-result counter.
module design_48_pipe #(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [1:0]    op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  y,
  output logic          flag,
  output logic [CW-1:0] count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  // Returns {flag, y}. Operands are unsigned: bit W of the widened add is the
  // carry, bit W of the widened subtract is the borrow (set iff opa < opb).
  function automatic logic [W:0] alu(input logic [W-1:0] opa,
                                     input logic [W-1:0] opb,
                                     input logic [1:0]   sel);
    logic [W:0]   ext;
    logic [W-1:0] r;
    ext = '0;
    r   = '0;
    case (sel)
      OP_ADD:  ext = {1'b0, opa} + {1'b0, opb};
      OP_SUB:  ext = {1'b0, opa} - {1'b0, opb};
      OP_AND: begin
        r   = opa & opb;
        ext = {(r == '0), r};
      end
      default: begin
        r   = opa ^ opb;
        ext = {(r == '0), r};
      end
    endcase
    return ext;
  endfunction

  logic [DEPTH-1:0] vld_p;
  logic [W-1:0]     y_p    [DEPTH];
  logic             flag_p [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             stall;
  logic             in_xfer;
  logic             out_xfer;
  logic [W:0]       res;
  logic [CW-1:0]    count_q;

  // A stage is blocked only if it and every stage after it are full and the
  // sink is not taking a result; walking back from the sink avoids a
  // combinational loop through adv.
  always_comb begin
    adv   = '0;
    stall = ~out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = vld_p[k] & ~stall;
      stall  = stall & vld_p[k];
    end
  end

  assign in_ready = ~vld_p[0] | adv[0];
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = vld_p[DEPTH-1] & out_ready;
  assign res      = alu(a, b, op);

  // Stage control: occupancy and delivered-result count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p   <= '0;
      count_q <= '0;
    end else begin
      if (in_xfer)
        vld_p[0] <= 1'b1;
      else if (adv[0])
        vld_p[0] <= 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k-1])
          vld_p[k] <= 1'b1;
        else if (adv[k])
          vld_p[k] <= 1'b0;
      end
      if (out_xfer)
        count_q <= count_q + CW'(1);
    end
  end

  // Stage payloads: loaded only when a result moves in, otherwise held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        y_p[k]    <= '0;
        flag_p[k] <= 1'b0;
      end
    end else begin
      if (in_xfer) begin
        y_p[0]    <= res[W-1:0];
        flag_p[0] <= res[W];
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k-1]) begin
          y_p[k]    <= y_p[k-1];
          flag_p[k] <= flag_p[k-1];
        end
      end
    end
  end

  // Output stage: driven straight from the last stage registers
  assign out_valid = vld_p[DEPTH-1];
  assign y         = y_p[DEPTH-1];
  assign flag      = flag_p[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_design_48_pipe.sv
// Directed bench for design_48_pipe (W=16, DEPTH=2, CW=8): vector table for the
// ALU plus hand-written backpressure, full-flow, reset and counter-wrap sequences.
module tb_design_48_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        flag;
  logic [7:0]  count;

  int         checks;
  int         errors;
  logic [7:0] exp_cnt;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] y;
    logic        f;
  } vec_t;

  vec_t vecs[11];

  design_48_pipe #(.W(16), .DEPTH(2), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flag      (flag),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Streams n add transactions (a = base+i, b = 1, so y = base+i+1, flag = 0).
  // out_ready is held low for the first 'stall' cycles, then high.
  task automatic stream(input logic [15:0] base, input int n, input int stall, input int max_cyc);
    int tx;
    int rx;
    int cyc;
    int rel;
    tx  = 0;
    rx  = 0;
    cyc = 0;
    rel = 0;
    while (rx < n && cyc < max_cyc) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      in_valid  = (tx < n);
      a         = 16'(base + tx);
      b         = 16'h0001;
      op        = 2'b00;
      #1;
      if (cyc >= 2 && cyc < stall) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_accepted", tx, 2);
        check("stall_out_valid", out_valid, 1);
        check("stall_y_hold", y, 16'(base + 1));
      end
      if (out_ready) rel++;
      if (out_ready && tx < n) check("flow_in_ready", in_ready, 1);
      if (out_valid && out_ready) begin
        check("stream_y", y, 16'(base + rx + 1));
        check("stream_flag", flag, 0);
        rx++;
      end
      if (in_valid && in_ready) tx++;
      cyc++;
    end
    if (rx < n) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d results, expected %0d", rx, n);
    end
    if (stall > 0) check("drain_cycles", rel, n);
    in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    checks    = 0;
    errors    = 0;
    exp_cnt   = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = 2'b00;

    vecs[0]  = '{16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1};
    vecs[1]  = '{16'h0003, 16'h0005, 2'b01, 16'hFFFE, 1'b1};
    vecs[2]  = '{16'h00F0, 16'h0F0F, 2'b10, 16'h0000, 1'b1};
    vecs[3]  = '{16'h1234, 16'h1234, 2'b11, 16'h0000, 1'b1};
    vecs[4]  = '{16'h1234, 16'h1111, 2'b00, 16'h2345, 1'b0};
    vecs[5]  = '{16'h0005, 16'h0003, 2'b01, 16'h0002, 1'b0};
    vecs[6]  = '{16'h0005, 16'h0005, 2'b01, 16'h0000, 1'b0};
    vecs[7]  = '{16'hFF00, 16'h0FF0, 2'b10, 16'h0F00, 1'b0};
    vecs[8]  = '{16'hA5A5, 16'h5A5A, 2'b11, 16'hFFFF, 1'b0};
    vecs[9]  = '{16'h8000, 16'h8000, 2'b00, 16'h0000, 1'b1};
    vecs[10] = '{16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b1};

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_flag", flag, 0);
    check("rst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_in_ready", in_ready, 1);

    // ALU vector table, one transaction at a time
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a         = vecs[i].a;
      b         = vecs[i].b;
      op        = vecs[i].op;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 check("vec_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      if (!out_valid) begin
        checks++;
        errors++;
        $display("FAIL vec_timeout: vector %0d produced no out_valid", i);
      end else begin
        check("vec_latency", lat, 2);
        check("vec_y", y, vecs[i].y);
        check("vec_flag", flag, vecs[i].f);
      end
      exp_cnt++;
      @(negedge clk);
      check("vec_count", count, exp_cnt);
      check("vec_out_valid_clear", out_valid, 0);
    end

    // Backpressure: 4 items with sink stalled, then released
    stream(16'h2000, 4, 5, 40);
    exp_cnt = exp_cnt + 8'd4;
    @(negedge clk);
    check("bp_count", count, exp_cnt);
    check("bp_empty", out_valid, 0);

    // Full pipeline then 10 cycles of simultaneous in/out
    stream(16'h1000, 12, 3, 60);
    exp_cnt = exp_cnt + 8'd12;
    @(negedge clk);
    check("flow_count", count, exp_cnt);

    // Reset mid-flight with two results in the pipeline
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 16'h0AAA;
    b         = 16'h0001;
    op        = 2'b00;
    @(negedge clk);
    a = 16'h0BBB;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("mid_full_valid", out_valid, 1);
    check("mid_full_in_ready", in_ready, 0);
    check("mid_full_y", y, 16'h0AAB);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_flag", flag, 0);
    check("mid_rst_count", count, 0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_cnt   = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", out_valid, 0);
      check("post_rst_count", count, 0);
      check("post_rst_in_ready", in_ready, 1);
    end

    // Counter wrap: 255 results, then one more
    stream(16'h0000, 255, 0, 300);
    @(negedge clk);
    check("wrap_count_ff", count, 8'hFF);
    stream(16'h0100, 1, 0, 10);
    @(negedge clk);
    check("wrap_count_00", count, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
